fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Program-counter and instruction-fetch stage that feeds the accumulator ALU. It holds the PC and drives the instruction ROM address. It presents the fetched instruction to decode and selects the next PC from the ALU's branch decision (br_comp) through a 32-entry branch-target LUT indexed by the 5-bit immediate field. It also owns the start/done handshake with the test harness.

Parameters:
PC_W, 10, PC / instruction ROM address width
INSTR_W, 9, instruction width
START_PC, 0, PC loaded on every start
HALT_INSTR, 9'h1FF, instruction encoding that halts the machine

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
start  in  1  begin execution from START_PC (level-sampled)
instr_in  in  INSTR_W  instruction word from combinational instruction ROM at pc_out
br_comp  in  1  ALU branch-taken decision for the instruction currently presented
lut_we  in  1  branch LUT write enable
lut_waddr  in  5  branch LUT write index
lut_wdata  in  PC_W  branch LUT write data (absolute target PC)
pc_out  out  PC_W  current PC, registered
instr_out  out  INSTR_W  instruction to decode; 0 when instr_valid=0
instr_valid  out  1  instr_out is executing this cycle
done  out  1  machine halted; held until next start
pc_wrap  out  1  sticky: PC overflowed past all-ones since last start

Behaviour:
- Reset (async, any state): state=IDLE, pc_out=0, done=0, pc_wrap=0, all 32 LUT entries=0. Reset mid-RUN abandons the program.
- States: IDLE, RUN, DONE. State and PC are registered. Outputs instr_out and instr_valid are combinational from the state.
- IDLE: instr_valid=0. With start=1, next cycle: state=RUN, pc_out=START_PC, pc_wrap=0.
- RUN: instr_valid=1, instr_out=instr_in. One instruction per cycle. Priority per cycle:
  1. instr_in==HALT_INSTR: state=DONE, PC holds, done=1 next cycle; br_comp is ignored.
  2. br_comp=1: pc_out <= lut[instr_in[4:0]].
  3. Otherwise: pc_out <= pc_out+1, modulo 2^PC_W. Wrap from all-ones to 0 sets pc_wrap; execution continues.
- start in RUN is ignored.
- DONE: instr_valid=0, done=1, PC holds. With start=1, next cycle: state=RUN, pc_out=START_PC, done=0, pc_wrap=0.
- LUT write is synchronous and allowed in any state.
- Same-cycle write and branch read of the same index: the branch uses the old entry (read-before-write). The new value is visible from the next cycle.
- Branch target latency: the target is on pc_out one cycle after the br_comp cycle. No delay slot and no bubble.
- br_comp sampled outside RUN has no effect.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs cyc_cnt[15:0] and br_taken_cnt[15:0].
  - cyc_cnt counts RUN cycles. br_taken_cnt counts cycles in RUN with br_comp=1 and no halt.
  - Both clear on reset and on start from IDLE/DONE, and saturate at 16'hFFFF.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, RUN, DONE}.
  - LUT_DEPTH=32 and LUT index width 5.
  - Immediate field slice position (bits 4:0), shared with the decoder.
- Sub-module branch_lut: 32 x PC_W register file with one synchronous write port, one combinational read port, and async reset to 0.

Test Plan:
- Reset asserted mid-RUN at pc=0x005 -> same cycle: pc_out=0, state IDLE, done=0, instr_valid=0; after release, LUT entry 3 reads 0.
- start with ROM of NOPs (9'h000), START_PC=0 -> pc_out sequence 0,1,2,3 on consecutive cycles; instr_valid=1 from the first RUN cycle.
- lut[7]=0x040; at pc=0x010, instr_in[4:0]=7 with br_comp=1 -> next pc_out=0x040, then 0x041.
- At pc=0x012, instr_in=HALT_INSTR and br_comp=1 -> next cycle done=1, pc_out stays 0x012, instr_valid=0; start -> pc_out=0, done=0.
- Same-cycle lut_we (idx 2, data 0x100) and branch via idx 2 (old value 0x020) -> pc_out=0x020; a later branch via idx 2 -> 0x100.
- PC at 0x3FF executing a non-branch instruction -> pc_out=0x000, pc_wrap=1 and sticky until the next start. With FETCH_PERF_EN, cyc_cnt matches the number of RUN cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, branch LUT geometry and immediate field position
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_IDX_W = 5;
  localparam int IMM_LSB = 0;
  localparam int IMM_MSB = 4;
endpackage

// File: rtl/branch_lut.sv
// branch_lut: 32 x PC_W branch-target register file, sync write, comb read, async clear (Clk, Reset, we/waddr/wdata, raddr -> rdata)
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]      wdata,
  input  logic [LUT_IDX_W-1:0] raddr,
  output logic [PC_W-1:0]      rdata
);
  logic [PC_W-1:0] mem [LUT_DEPTH];
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC + instruction fetch with LUT branch targets and start/done handshake; ports Clk, Reset, start, instr_in, br_comp, lut_we/waddr/wdata -> pc_out, instr_out, instr_valid, done, pc_wrap (+ cyc_cnt, br_taken_cnt when FETCH_PERF_EN is defined)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   PC_W       = 10,
  parameter int                   INSTR_W    = 9,
  parameter logic [PC_W-1:0]      START_PC   = '0,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 9'h1FF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [INSTR_W-1:0]   instr_in,
  input  logic                 br_comp,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc_out,
  output logic [INSTR_W-1:0]   instr_out,
  output logic                 instr_valid,
  output logic                 done,
  output logic                 pc_wrap
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]          cyc_cnt,
  output logic [15:0]          br_taken_cnt
`endif
);
  state_t state;
  logic [PC_W-1:0] target;
  logic halt, take_br, launch;
  branch_lut #(.PC_W(PC_W)) u_lut (
    .Clk(Clk), .Reset(Reset), .we(lut_we), .waddr(lut_waddr), .wdata(lut_wdata),
    .raddr(instr_in[IMM_MSB:IMM_LSB]), .rdata(target)
  );
  assign instr_valid = state == RUN;
  assign instr_out = instr_valid ? instr_in : '0;
  assign done = state == DONE;
  assign halt = instr_valid && instr_in == HALT_INSTR;
  assign take_br = instr_valid && br_comp && !halt;
  assign launch = !instr_valid && start;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      pc_out <= '0;
      pc_wrap <= 1'b0;
    end else if (launch) begin
      state <= RUN;
      pc_out <= START_PC;
      pc_wrap <= 1'b0;
    end else if (halt) state <= DONE;
    else if (take_br) pc_out <= target;
    else if (instr_valid) begin
      pc_out <= pc_out + 1'b1;
      if (&pc_out) pc_wrap <= 1'b1;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge Clk or posedge Reset)
    if (Reset || launch) begin
      cyc_cnt <= '0;
      br_taken_cnt <= '0;
    end else if (instr_valid) begin
      cyc_cnt <= cyc_cnt + {15'd0, ~&cyc_cnt};
      br_taken_cnt <= br_taken_cnt + {15'd0, take_br && ~&br_taken_cnt};
    end
`endif
endmodule
